// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - snoops a scanned active-low 7-segment bus and recovers each digit's BCD value
// Optional macro SEG7_SCAN_DP_EN adds the decimal-point input dp_n and per-digit output dp_o.
module seg7_scan_decoder #(
    parameter int NDIG          = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          seg_n,
    input  logic [NDIG-1:0]     an_n,
`ifdef SEG7_SCAN_DP_EN
    input  logic                dp_n,
    output logic [NDIG-1:0]     dp_o,
`endif
    output logic [4*NDIG-1:0]   digits_o,
    output logic [NDIG-1:0]     valid_o,
    output logic [NDIG-1:0]     err_o,
    output logic                upd_o,
    output logic                frame_o
);

    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

`ifdef SEG7_SCAN_DP_EN
    localparam int SW = NDIG + 8;
    logic [SW-1:0] w_sample;
    assign w_sample = {dp_n, an_n, seg_n};
`else
    localparam int SW = NDIG + 7;
    logic [SW-1:0] w_sample;
    assign w_sample = {an_n, seg_n};
`endif

    typedef enum logic {ST_SETTLE, ST_HELD} state_t;

    state_t           r_state;
    logic [SW-1:0]    r_s;
    logic [CW-1:0]    r_cnt;
    logic [NDIG-1:0]  r_mask;

    logic             w_chg;
    logic [NDIG-1:0]  w_act;
    logic             w_onehot;
    logic             w_commit;
    logic [NDIG-1:0]  w_mask_nxt;
    logic [5:0]       w_dec;

    // {valid, err, value} for an active-high abcdefg pattern
    function automatic logic [5:0] f_decode(input logic [6:0] seg);
        case (seg)
            7'b1111110: f_decode = {2'b10, 4'd0};
            7'b0110000: f_decode = {2'b10, 4'd1};
            7'b1101101: f_decode = {2'b10, 4'd2};
            7'b1111001: f_decode = {2'b10, 4'd3};
            7'b0110011: f_decode = {2'b10, 4'd4};
            7'b1011011: f_decode = {2'b10, 4'd5};
            7'b1011111: f_decode = {2'b10, 4'd6};
            7'b1110000: f_decode = {2'b10, 4'd7};
            7'b1111111: f_decode = {2'b10, 4'd8};
            7'b1111011: f_decode = {2'b10, 4'd9};
            7'b0000000: f_decode = {2'b10, 4'hF};
            default:    f_decode = {2'b01, 4'hE};
        endcase
    endfunction

    // Change is judged as the new sample lands in r_s, so a hold from edge k commits at k+STABLE_CYCLES.
    assign w_chg      = (w_sample != r_s);
    assign w_act      = ~r_s[NDIG+6:7];
    assign w_onehot   = (w_act != '0) && ((w_act & (w_act - NDIG'(1))) == '0);
    assign w_commit   = (r_state == ST_SETTLE) && !w_chg && (r_cnt == CNT_MAX) && w_onehot;
    assign w_mask_nxt = r_mask | w_act;
    assign w_dec      = f_decode(~r_s[6:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_SETTLE;
            r_s      <= '1;
            r_cnt    <= '0;
            r_mask   <= '0;
            digits_o <= '0;
            valid_o  <= '0;
            err_o    <= '0;
            upd_o    <= 1'b0;
            frame_o  <= 1'b0;
`ifdef SEG7_SCAN_DP_EN
            dp_o     <= '0;
`endif
        end else begin
            r_s     <= w_sample;
            upd_o   <= 1'b0;
            frame_o <= 1'b0;

            case (r_state)
                ST_SETTLE: begin
                    if (w_chg)
                        r_cnt <= '0;
                    else if (r_cnt == CNT_MAX)
                        r_state <= ST_HELD;
                    else
                        r_cnt <= r_cnt + 1'b1;
                end
                ST_HELD: begin
                    if (w_chg) begin
                        r_state <= ST_SETTLE;
                        r_cnt   <= '0;
                    end
                end
                default: r_state <= ST_SETTLE;
            endcase

            if (w_commit) begin
                upd_o <= 1'b1;
                if (&w_mask_nxt) begin
                    frame_o <= 1'b1;
                    r_mask  <= '0;
                end else begin
                    r_mask  <= w_mask_nxt;
                end
                for (int i = 0; i < NDIG; i++) begin
                    if (w_act[i]) begin
                        digits_o[4*i +: 4] <= w_dec[3:0];
                        valid_o[i]         <= w_dec[5];
                        err_o[i]           <= w_dec[4];
`ifdef SEG7_SCAN_DP_EN
                        dp_o[i]            <= ~r_s[SW-1];
`endif
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - directed and randomized check of seg7_scan_decoder against a behavioural model
module tb_seg7_scan_decoder;

    localparam int NDIG = 8;
    localparam int SC   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg_n = '1;
    logic [7:0]  an_n = '1;
    logic [31:0] digits_o;
    logic [7:0]  valid_o;
    logic [7:0]  err_o;
    logic        upd_o;
    logic        frame_o;

    always #5 clk = ~clk;

    seg7_scan_decoder #(.NDIG(NDIG), .STABLE_CYCLES(SC)) dut (
        .clk      (clk),
        .rst      (rst),
        .seg_n    (seg_n),
        .an_n     (an_n),
        .digits_o (digits_o),
        .valid_o  (valid_o),
        .err_o    (err_o),
        .upd_o    (upd_o),
        .frame_o  (frame_o)
    );

    logic [6:0] seg_tbl [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: a digit commits once its {an,seg} sample has been seen on SC+1 consecutive edges.
    logic [3:0]  m_dig [NDIG];
    bit          m_val [NDIG];
    bit          m_err [NDIG];
    bit          m_seen [NDIG];
    logic [14:0] m_last;
    int          m_run;
    bit          m_done;
    bit          m_upd;
    bit          m_frame;

    function automatic logic [5:0] mdec(input logic [6:0] sn);
        logic [6:0] a;
        a = ~sn;
        if (a == 7'd0) return {2'b10, 4'hF};
        for (int v = 0; v < 10; v++)
            if (a == seg_tbl[v]) return {2'b10, 4'(v)};
        return {2'b01, 4'hE};
    endfunction

    task automatic model_edge(input bit r, input logic [7:0] an, input logic [6:0] seg);
        int lows;
        int idx;
        int seen_all;
        logic [5:0] d;
        m_upd   = 0;
        m_frame = 0;
        if (r) begin
            for (int i = 0; i < NDIG; i++) begin
                m_dig[i] = 0; m_val[i] = 0; m_err[i] = 0; m_seen[i] = 0;
            end
            m_last = '1;
            m_run  = 1;
            m_done = 0;
            return;
        end
        if ({an, seg} != m_last) begin
            m_last = {an, seg};
            m_run  = 1;
            m_done = 0;
            return;
        end
        m_run++;
        if (m_done || m_run < SC + 1) return;
        m_done = 1;
        lows = 0;
        idx  = 0;
        for (int i = 0; i < NDIG; i++)
            if (!an[i]) begin lows++; idx = i; end
        if (lows != 1) return;
        d = mdec(seg);
        m_dig[idx]  = d[3:0];
        m_val[idx]  = d[5];
        m_err[idx]  = d[4];
        m_seen[idx] = 1;
        m_upd = 1;
        seen_all = 1;
        for (int i = 0; i < NDIG; i++) if (!m_seen[i]) seen_all = 0;
        if (seen_all != 0) begin
            m_frame = 1;
            for (int i = 0; i < NDIG; i++) m_seen[i] = 0;
        end
    endtask

    int n_upd = 0, n_frame = 0, cyc = 0, last_upd_cyc = -1, frame_at = -1;
    bit frame_coinc = 0;

    task automatic tick(input bit r, input logic [7:0] an, input logic [6:0] seg);
        logic [31:0] ed;
        logic [7:0]  ev, ee;
        @(negedge clk);
        rst = r; an_n = an; seg_n = seg;
        @(posedge clk);
        model_edge(r, an, seg);
        #1;
        for (int i = 0; i < NDIG; i++) begin
            ed[4*i +: 4] = m_dig[i];
            ev[i] = m_val[i];
            ee[i] = m_err[i];
        end
        chk("digits", 64'(digits_o), 64'(ed));
        chk("valid", 64'(valid_o), 64'(ev));
        chk("err", 64'(err_o), 64'(ee));
        chk("upd", 64'(upd_o), 64'(m_upd));
        chk("frame", 64'(frame_o), 64'(m_frame));
        if (upd_o) begin n_upd++; last_upd_cyc = cyc; end
        if (frame_o) begin n_frame++; frame_at = n_upd; frame_coinc = upd_o; end
        cyc++;
    endtask

    int base_u, base_f, r_cyc;
    logic [7:0] an_r;
    logic [6:0] seg_r;

    initial begin
        repeat (2) tick(1, 8'hFF, 7'h7F);
        chk("rst_digits", 64'(digits_o), 64'd0);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        base_u = n_upd; base_f = n_frame;
        repeat (20) tick(0, 8'hFF, 7'h7F);
        chk("idle_upd", 64'(n_upd - base_u), 64'd0);
        chk("idle_frame", 64'(n_frame - base_f), 64'd0);

        base_u = n_upd;
        repeat (10) tick(0, 8'hFE, 7'b1001111);
        chk("legal_val", 64'(digits_o[3:0]), 64'd1);
        chk("legal_valid", 64'(valid_o[0]), 64'd1);
        chk("legal_err", 64'(err_o[0]), 64'd0);
        chk("legal_upds", 64'(n_upd - base_u), 64'd1);

        base_u = n_upd;
        repeat (2) tick(0, 8'hFD, ~seg_tbl[2]);
        repeat (6) tick(0, 8'hFD, 7'b0100100);
        chk("glitch_val", 64'(digits_o[7:4]), 64'd5);
        chk("glitch_upds", 64'(n_upd - base_u), 64'd1);

        repeat (6) tick(0, 8'hF7, ~7'b1000000);
        chk("illegal_val", 64'(digits_o[15:12]), 64'hE);
        chk("illegal_err", 64'(err_o[3]), 64'd1);
        chk("illegal_valid", 64'(valid_o[3]), 64'd0);
        repeat (6) tick(0, 8'hF7, 7'h7F);
        chk("blank_val", 64'(digits_o[15:12]), 64'hF);
        chk("blank_valid", 64'(valid_o[3]), 64'd1);
        chk("blank_err", 64'(err_o[3]), 64'd0);

        repeat (2) tick(1, 8'hFF, 7'h7F);
        base_u = n_upd; base_f = n_frame;
        for (int i = 0; i < NDIG; i++)
            repeat (6) tick(0, ~(8'h01 << i), ~seg_tbl[i]);
        chk("frame_digits", 64'(digits_o), 64'h76543210);
        chk("frame_count", 64'(n_frame - base_f), 64'd1);
        chk("frame_at_8th", 64'(frame_at - base_u), 64'd8);
        chk("frame_coinc", 64'(frame_coinc), 64'd1);
        base_u = n_upd; base_f = n_frame;
        repeat (6) tick(0, 8'hFE, ~seg_tbl[0]);
        chk("rescan_upds", 64'(n_upd - base_u), 64'd1);
        chk("rescan_frame", 64'(n_frame - base_f), 64'd0);

        base_u = n_upd;
        repeat (10) tick(0, 8'hFC, ~seg_tbl[3]);
        chk("badan_upds", 64'(n_upd - base_u), 64'd0);
        repeat (2) tick(0, 8'hFE, ~seg_tbl[8]);
        tick(1, 8'hFE, ~seg_tbl[8]);
        r_cyc = cyc - 1;
        base_u = n_upd;
        repeat (8) tick(0, 8'hFE, ~seg_tbl[8]);
        chk("rst_hold_upds", 64'(n_upd - base_u), 64'd1);
        chk("rst_hold_lat", 64'(last_upd_cyc - r_cyc), 64'd5);
        chk("rst_hold_val", 64'(digits_o[3:0]), 64'd8);

        repeat (400) begin
            int k, s, hold;
            k = $urandom_range(0, 9);
            if (k < 7)       an_r = ~(8'h01 << $urandom_range(0, 7));
            else if (k == 7) an_r = 8'hFF;
            else             an_r = ~((8'h01 << $urandom_range(0, 7)) | (8'h01 << $urandom_range(0, 7)));
            s = $urandom_range(0, 9);
            if (s < 7)       seg_r = ~seg_tbl[$urandom_range(0, 9)];
            else if (s == 7) seg_r = 7'h7F;
            else             seg_r = 7'($urandom);
            hold = $urandom_range(1, 7);
            if ($urandom_range(0, 49) == 0) tick(1, an_r, seg_r);
            repeat (hold) tick(0, an_r, seg_r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
